// File: rtl/operand_fetch.sv
// Register-read stage: architectural register file, rs1/rs2 read with
// prioritised bypass, immediate generation, and a valid/ready output slice
// with flush and operand refresh while the output is stalled.
module operand_fetch #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned NUM_BYP  = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [31:0]             in_ir,
   input  logic [XLEN-1:0]         in_pc,
   input  logic                    wb_valid,
   input  logic [4:0]              wb_addr,
   input  logic [XLEN-1:0]         wb_data,
   input  logic [NUM_BYP-1:0]      byp_valid,
   input  logic [5*NUM_BYP-1:0]    byp_addr,
   input  logic [XLEN*NUM_BYP-1:0] byp_data,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_ir,
   output logic [XLEN-1:0]         out_pc,
   output logic [XLEN-1:0]         out_a,
   output logic [XLEN-1:0]         out_b,
   output logic [XLEN-1:0]         out_imm,
   output logic                    out_illegal
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // Array spans the full 5-bit index space; entries at or above NUM_REGS
   // are never written, so they stay at their reset value of zero.
   logic [XLEN-1:0] regs [32];

   logic            accept;
   logic            held;
   logic [4:0]      src_idx  [4];
   logic            src_zero [4];
   logic [XLEN-1:0] src_val  [4];
   logic [XLEN-1:0] dec_imm;
   logic            dec_illegal;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready && !flush;
   assign held     = out_valid && !out_ready;

   // Operand resolution for incoming rs1/rs2 (0,1) and held rs1/rs2 (2,3)
   always_comb begin
      src_idx[0]  = in_ir[19:15];
      src_idx[1]  = in_ir[24:20];
      src_idx[2]  = out_ir[19:15];
      src_idx[3]  = out_ir[24:20];
      src_zero[0] = (in_ir[19:15] == 5'd0) || (in_ir[6:0] == OPC_LUI);
      src_zero[1] = (in_ir[24:20] == 5'd0);
      src_zero[2] = (out_ir[19:15] == 5'd0) || (out_ir[6:0] == OPC_LUI);
      src_zero[3] = (out_ir[24:20] == 5'd0);
      for (int unsigned s = 0; s < 4; s++) begin
         logic hit;
         hit        = 1'b0;
         src_val[s] = '0;
         if (src_zero[s]) begin
            hit = 1'b1;
         end
         for (int unsigned k = 0; k < NUM_BYP; k++) begin
            if (!hit && byp_valid[k] && (byp_addr[5*k +: 5] == src_idx[s])) begin
               src_val[s] = byp_data[XLEN*k +: XLEN];
               hit        = 1'b1;
            end
         end
         if (!hit && wb_valid && (wb_addr == src_idx[s])) begin
            src_val[s] = wb_data;
            hit        = 1'b1;
         end
         if (!hit && (32'(src_idx[s]) < NUM_REGS)) begin
            src_val[s] = regs[src_idx[s]];
         end
      end
   end

   // Immediate generation and opcode legality for the incoming instruction
   always_comb begin
      logic [31:0] imm32;
      imm32       = '0;
      dec_illegal = 1'b0;
      case (in_ir[6:0])
         OPC_LUI, OPC_AUIPC: imm32 = {in_ir[31:12], 12'b0};
         OPC_JAL:            imm32 = {{12{in_ir[31]}}, in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0};
         OPC_JALR, OPC_LOAD: imm32 = {{20{in_ir[31]}}, in_ir[31:20]};
         OPC_OPIMM: begin
            if (in_ir[13:12] == 2'b01)
               imm32 = {27'b0, in_ir[24:20]};
            else
               imm32 = {{20{in_ir[31]}}, in_ir[31:20]};
         end
         OPC_STORE:          imm32 = {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
         OPC_BRANCH:         imm32 = {{19{in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0};
         OPC_OP, OPC_FENCE, OPC_SYSTEM: imm32 = '0;
         default:            dec_illegal = 1'b1;
      endcase
      dec_imm = XLEN'($signed(imm32));
   end

   // Register file write; x0 and out-of-range indices are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
      end else if (wb_valid && (wb_addr != 5'd0) && (32'(wb_addr) < NUM_REGS)) begin
         regs[wb_addr] <= wb_data;
      end
   end

   // Output slice: flush beats accept beats hold; a stalled slot re-reads its operands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_ir      <= '0;
         out_pc      <= '0;
         out_a       <= '0;
         out_b       <= '0;
         out_imm     <= '0;
         out_illegal <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid   <= 1'b1;
         out_ir      <= in_ir;
         out_pc      <= in_pc;
         out_a       <= src_val[0];
         out_b       <= src_val[1];
         out_imm     <= dec_imm;
         out_illegal <= dec_illegal;
      end else if (held) begin
         out_a <= src_val[2];
         out_b <= src_val[3];
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a default instance and a 16-register
// instance share all inputs.
module tb_operand_fetch;

   logic        clk, rst_n;
   logic        in_valid, in_ready, in_ready16;
   logic [31:0] in_ir, in_pc;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [1:0]  byp_valid;
   logic [9:0]  byp_addr;
   logic [63:0] byp_data;
   logic        flush, out_ready;
   logic        out_valid, out_illegal, out_valid16, out_illegal16;
   logic [31:0] out_ir, out_pc, out_a, out_b, out_imm;
   logic [31:0] out_ir16, out_pc16, out_a16, out_b16, out_imm16;

   int total = 0;
   int bad   = 0;

   localparam logic [31:0] ADDI_X6 = 32'hFFF28313;
   localparam logic [31:0] ADD_X7  = 32'h007380B3;
   localparam logic [31:0] SUB_X34 = 32'h40418133;
   localparam logic [31:0] LUI_I   = 32'h123450B7;
   localparam logic [31:0] SRAI_I  = 32'h40305093;
   localparam logic [31:0] SW_I    = 32'hFE002E23;
   localparam logic [31:0] BGEU_I  = 32'hFE007EE3;
   localparam logic [31:0] BAD_I   = 32'hFFF0007F;
   localparam logic [31:0] ADD_X20 = 32'h014A00B3;
   localparam logic [31:0] ADD_X0  = 32'h000000B3;

   operand_fetch #(.XLEN(32), .NUM_REGS(32), .NUM_BYP(2)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_ir(in_ir), .in_pc(in_pc), .wb_valid(wb_valid), .wb_addr(wb_addr),
      .wb_data(wb_data), .byp_valid(byp_valid), .byp_addr(byp_addr),
      .byp_data(byp_data), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_ir(out_ir), .out_pc(out_pc), .out_a(out_a),
      .out_b(out_b), .out_imm(out_imm), .out_illegal(out_illegal)
   );

   operand_fetch #(.XLEN(32), .NUM_REGS(16), .NUM_BYP(2)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
      .in_ir(in_ir), .in_pc(in_pc), .wb_valid(wb_valid), .wb_addr(wb_addr),
      .wb_data(wb_data), .byp_valid(byp_valid), .byp_addr(byp_addr),
      .byp_data(byp_data), .flush(flush), .out_valid(out_valid16),
      .out_ready(out_ready), .out_ir(out_ir16), .out_pc(out_pc16), .out_a(out_a16),
      .out_b(out_b16), .out_imm(out_imm16), .out_illegal(out_illegal16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] ir, input logic [31:0] pc);
      in_valid = 1'b1;
      in_ir    = ir;
      in_pc    = pc;
   endtask

   task automatic idle_inputs();
      in_valid  = 1'b0;
      wb_valid  = 1'b0;
      byp_valid = 2'b00;
      flush     = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_ir = '0; in_pc = '0;
      wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
      byp_valid = '0; byp_addr = '0; byp_data = '0;
      flush = 1'b0; out_ready = 1'b1;
      step(); step();
      chk("rst_valid",   32'(out_valid), 32'd0);
      chk("rst_ir",      out_ir, 32'd0);
      chk("rst_a",       out_a, 32'd0);
      chk("rst_imm",     out_imm, 32'd0);
      chk("rst_illegal", 32'(out_illegal), 32'd0);
      rst_n = 1'b1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // 1: write x5, then ADDI x6,x5,-1
      wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
      step();
      wb_valid = 1'b0;
      issue(ADDI_X6, 32'h100);
      step();
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_a",     out_a, 32'h1234);
      chk("t1_imm",   out_imm, 32'hFFFFFFFF);
      chk("t1_pc",    out_pc, 32'h100);
      chk("t1_ir",    out_ir, ADDI_X6);

      // 2: bypass slot1 beats write-through; slot0 beats slot1
      issue(ADD_X7, 32'h104);
      wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'hAA;
      byp_valid = 2'b10; byp_addr = {5'd7, 5'd7}; byp_data = {32'hBB, 32'h11};
      step();
      chk("t2_a_slot1", out_a, 32'hBB);
      chk("t2_b_slot1", out_b, 32'hBB);
      wb_valid = 1'b0;
      byp_valid = 2'b11; byp_data = {32'hBB, 32'hCC};
      step();
      chk("t2_a_slot0", out_a, 32'hCC);
      chk("t2_b_slot0", out_b, 32'hCC);
      byp_valid = 2'b00;
      step();
      chk("t2_a_regfile", out_a, 32'hAA);
      chk("t2_imm_op",    out_imm, 32'd0);

      // 3: stall with SUB x2,x3,x4 held, write x3 mid-stall
      idle_inputs();
      wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'd1;
      step();
      wb_valid = 1'b0;
      chk("t3_drain", 32'(out_valid), 32'd0);
      issue(SUB_X34, 32'h200);
      out_ready = 1'b0;
      step();
      chk("t3_valid", 32'(out_valid), 32'd1);
      chk("t3_a_old", out_a, 32'd1);
      issue(ADDI_X6, 32'h204);
      wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'd9;
      chk("t3_in_ready", 32'(in_ready), 32'd0);
      step();
      wb_valid = 1'b0;
      chk("t3_a_fresh", out_a, 32'd9);
      chk("t3_ir_held", out_ir, SUB_X34);
      chk("t3_pc_held", out_pc, 32'h200);
      chk("t3_valid_held", 32'(out_valid), 32'd1);

      // 4: flush while held with an incoming instruction
      flush = 1'b1;
      chk("t4_in_ready", 32'(in_ready), 32'd0);
      step();
      chk("t4_flushed", 32'(out_valid), 32'd0);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step();
      chk("t4_no_late", 32'(out_valid), 32'd0);
      chk("t4_ir_not_addi", 32'(out_ir == ADDI_X6), 32'd0);
      issue(ADDI_X6, 32'h300);
      flush = 1'b1;
      chk("t4_idle_ready", 32'(in_ready), 32'd1);
      step();
      chk("t4_idle_drop", 32'(out_valid), 32'd0);
      flush = 1'b0;
      step();
      chk("t4_resume", 32'(out_valid), 32'd1);
      chk("t4_resume_pc", out_pc, 32'h300);

      // 5: immediates and illegal opcode
      issue(BGEU_I, 32'h400);
      step();
      chk("t5_bgeu_imm", out_imm, 32'hFFFFFFFC);
      chk("t5_bgeu_ill", 32'(out_illegal), 32'd0);
      issue(BAD_I, 32'h404);
      step();
      chk("t5_bad_ill", 32'(out_illegal), 32'd1);
      chk("t5_bad_imm", out_imm, 32'd0);
      issue(LUI_I, 32'h408);
      byp_valid = 2'b01; byp_addr = {5'd0, 5'd8}; byp_data = {32'd0, 32'hDEAD};
      step();
      byp_valid = 2'b00;
      chk("t5_lui_imm", out_imm, 32'h12345000);
      chk("t5_lui_a",   out_a, 32'd0);
      issue(SRAI_I, 32'h40C);
      step();
      chk("t5_srai_imm", out_imm, 32'd3);
      issue(SW_I, 32'h410);
      step();
      chk("t5_sw_imm", out_imm, 32'hFFFFFFFC);

      // 6: NUM_REGS=16 range limit, x0 writes, async reset mid-stall
      idle_inputs();
      wb_valid = 1'b1; wb_addr = 5'd20; wb_data = 32'h55;
      step();
      wb_valid = 1'b0;
      issue(ADD_X20, 32'h500);
      step();
      chk("t6_x20_full", out_a, 32'h55);
      chk("t6_x20_e",    out_a16, 32'd0);
      chk("t6_x20_e_b",  out_b16, 32'd0);
      issue(ADD_X0, 32'h504);
      wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFF;
      step();
      wb_valid = 1'b0;
      chk("t6_x0_same", out_a, 32'd0);
      step();
      chk("t6_x0_after", out_a, 32'd0);
      chk("t6_x0_after_e", out_b16, 32'd0);
      issue(SUB_X34, 32'h508);
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      chk("t6_stall_valid", 32'(out_valid), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6_async_valid",   32'(out_valid), 32'd0);
      chk("t6_async_valid_e", 32'(out_valid16), 32'd0);
      chk("t6_async_a",       out_a, 32'd0);
      chk("t6_async_ir",      out_ir, 32'd0);
      step();
      rst_n = 1'b1;
      chk("t6_post_ready", 32'(in_ready), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
